// File: rtl/timer_pkg.sv
// Shared widths, reset constants and the byte-merge helper for the 64-bit timer.
package timer_pkg;

    localparam int unsigned CNT_W  = 64;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned STRB_W = HALF_W / 8;

    localparam logic [CNT_W-1:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the bytes of old_val whose strobe bit is set.
    function automatic logic [HALF_W-1:0] byte_merge(
        input logic [HALF_W-1:0] old_val,
        input logic [HALF_W-1:0] wdata,
        input logic [STRB_W-1:0] wstrb
    );
        logic [HALF_W-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_int_ctrl.sv
// Sticky match/overflow status bits with set-over-clear priority and interrupt gating.
module timer_int_ctrl
    import timer_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic match,
    input  logic ovf_set,
    input  logic int_clr,
    input  logic ovf_clr,
    input  logic int_en,
    output logic int_st,
    output logic ovf_st,
    output logic tim_int
);

    logic int_st_d;
    logic ovf_st_d;

    always_comb begin
        int_st_d = int_st;
        ovf_st_d = ovf_st;
        if (match) begin
            int_st_d = 1'b1;
        end else if (int_clr) begin
            int_st_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_st_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_st_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            int_st <= 1'b0;
            ovf_st <= 1'b0;
        end else begin
            int_st <= int_st_d;
            ovf_st <= ovf_st_d;
        end
    end

    // Masking only; int_st itself is never touched by int_en.
    assign tim_int = int_st & int_en;

endmodule

// File: rtl/timer_counter.sv
// 64-bit free-running timer with byte-writable counter/compare halves and match/wrap status.
module timer_counter
    import timer_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              timer_en,
    input  logic              cnt_en,
    input  logic              cnt_lo_wr,
    input  logic              cnt_hi_wr,
    input  logic              cmp_lo_wr,
    input  logic              cmp_hi_wr,
    input  logic [HALF_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              int_en,
    input  logic              int_clr,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  cmp,
    output logic              int_st,
    output logic              ovf_st,
    output logic              tim_int
);

    logic             en_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cmp_d;
    logic             cnt_wr;
    logic             en_fall;
    logic             inc;
    logic             ovf_set;
    logic             match;

    // Counter priority: register write, then disable-clear, then tick.
    always_comb begin
        cnt_d   = cnt;
        cmp_d   = cmp;
        cnt_wr  = cnt_lo_wr | cnt_hi_wr;
        en_fall = en_q & ~timer_en;
        inc     = 1'b0;
        if (cnt_wr) begin
            if (cnt_lo_wr) begin
                cnt_d[HALF_W-1:0] = byte_merge(cnt[HALF_W-1:0], wdata, wstrb);
            end
            if (cnt_hi_wr) begin
                cnt_d[CNT_W-1:HALF_W] = byte_merge(cnt[CNT_W-1:HALF_W], wdata, wstrb);
            end
        end else if (en_fall) begin
            cnt_d = '0;
        end else if (timer_en && cnt_en) begin
            inc   = 1'b1;
            cnt_d = cnt + CNT_W'(1);
        end
        if (cmp_lo_wr) begin
            cmp_d[HALF_W-1:0] = byte_merge(cmp[HALF_W-1:0], wdata, wstrb);
        end
        if (cmp_hi_wr) begin
            cmp_d[CNT_W-1:HALF_W] = byte_merge(cmp[CNT_W-1:HALF_W], wdata, wstrb);
        end
        ovf_set = inc & (&cnt);
        match   = (cnt == cmp);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt  <= '0;
            cmp  <= CMP_RST;
            en_q <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            cmp  <= cmp_d;
            en_q <= timer_en;
        end
    end

    timer_int_ctrl u_int_ctrl (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .match     (match),
        .ovf_set   (ovf_set),
        .int_clr   (int_clr),
        .ovf_clr   (ovf_clr),
        .int_en    (int_en),
        .int_st    (int_st),
        .ovf_st    (ovf_st),
        .tim_int   (tim_int)
    );

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed cases plus randomized traffic vs. a behavioural model.
module tb_timer_counter;
    import timer_pkg::*;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        timer_en  = 1'b0;
    logic        cnt_en    = 1'b0;
    logic        cnt_lo_wr = 1'b0;
    logic        cnt_hi_wr = 1'b0;
    logic        cmp_lo_wr = 1'b0;
    logic        cmp_hi_wr = 1'b0;
    logic [31:0] wdata     = '0;
    logic [3:0]  wstrb     = '0;
    logic        int_en    = 1'b0;
    logic        int_clr   = 1'b0;
    logic        ovf_clr   = 1'b0;
    logic [63:0] cnt;
    logic [63:0] cmp;
    logic        int_st;
    logic        ovf_st;
    logic        tim_int;

    timer_counter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .timer_en  (timer_en),
        .cnt_en    (cnt_en),
        .cnt_lo_wr (cnt_lo_wr),
        .cnt_hi_wr (cnt_hi_wr),
        .cmp_lo_wr (cmp_lo_wr),
        .cmp_hi_wr (cmp_hi_wr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .int_en    (int_en),
        .int_clr   (int_clr),
        .ovf_clr   (ovf_clr),
        .cnt       (cnt),
        .cmp       (cmp),
        .int_st    (int_st),
        .ovf_st    (ovf_st),
        .tim_int   (tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        ten, cen, clw, chw, mlw, mhw;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        ien, iclr, oclr;
    } stim_t;

    typedef struct {
        logic [63:0] cnt, cmp;
        logic        ist, ost, tint;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [63:0] m_cnt, m_cmp;
    logic        m_ist, m_ost, m_en;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] wd,
                                            input logic [3:0] ws);
        logic [31:0] mask;
        mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        return (old_v & ~mask) | (wd & mask);
    endfunction

    function automatic stim_t quiet(input logic ten, input logic ien);
        stim_t s;
        s.ten = ten; s.cen = 1'b0; s.clw = 1'b0; s.chw = 1'b0; s.mlw = 1'b0; s.mhw = 1'b0;
        s.wd = '0; s.ws = '0; s.ien = ien; s.iclr = 1'b0; s.oclr = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        m_cnt = '0; m_cmp = CMP_RST; m_ist = 1'b0; m_ost = 1'b0; m_en = 1'b0;
    endtask

    // Apply one cycle of stimulus, predict the post-edge state, queue it, wait for the next negedge.
    task automatic step(input stim_t s, input string nm);
        exp_t        e;
        logic        wr, inc;
        logic [63:0] nc, nm_cmp;
        timer_en = s.ten; cnt_en = s.cen; cnt_lo_wr = s.clw; cnt_hi_wr = s.chw;
        cmp_lo_wr = s.mlw; cmp_hi_wr = s.mhw; wdata = s.wd; wstrb = s.ws;
        int_en = s.ien; int_clr = s.iclr; ovf_clr = s.oclr;
        wr  = s.clw | s.chw;
        inc = !wr && s.ten && s.cen;
        nc  = m_cnt;
        if (s.clw) nc[31:0]  = merge32(m_cnt[31:0], s.wd, s.ws);
        if (s.chw) nc[63:32] = merge32(m_cnt[63:32], s.wd, s.ws);
        if (!wr && m_en && !s.ten) nc = 64'd0;
        else if (inc) nc = m_cnt + 64'd1;
        nm_cmp = m_cmp;
        if (s.mlw) nm_cmp[31:0]  = merge32(m_cmp[31:0], s.wd, s.ws);
        if (s.mhw) nm_cmp[63:32] = merge32(m_cmp[63:32], s.wd, s.ws);
        e.ost  = (inc && nc == 64'd0) ? 1'b1 : (s.oclr ? 1'b0 : m_ost);
        e.ist  = (m_cnt == m_cmp) ? 1'b1 : (s.iclr ? 1'b0 : m_ist);
        e.cnt  = nc;
        e.cmp  = nm_cmp;
        e.tint = e.ist & s.ien;
        e.name = nm;
        m_cnt = nc; m_cmp = nm_cmp; m_ist = e.ist; m_ost = e.ost; m_en = s.ten;
        exp_q.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic wr64(input logic is_cmp, input logic [63:0] v, input logic ten, input logic ien);
        stim_t s;
        s = quiet(ten, ien); s.ws = 4'hF; s.wd = v[31:0];
        if (is_cmp) s.mlw = 1'b1; else s.clw = 1'b1;
        step(s, is_cmp ? "cmp_lo_write" : "cnt_lo_write");
        s = quiet(ten, ien); s.ws = 4'hF; s.wd = v[63:32];
        if (is_cmp) s.mhw = 1'b1; else s.chw = 1'b1;
        step(s, is_cmp ? "cmp_hi_write" : "cnt_hi_write");
    endtask

    task automatic tick(input int n, input logic ien);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = quiet(1'b1, ien); s.cen = 1'b1;
            step(s, "tick");
        end
    endtask

    // Monitor: compare every queued expectation just after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".cnt"}, cnt, e.cnt);
                chk({e.name, ".cmp"}, cmp, e.cmp);
                chk({e.name, ".int_st"}, 64'(int_st), 64'(e.ist));
                chk({e.name, ".ovf_st"}, 64'(ovf_st), 64'(e.ost));
                chk({e.name, ".tim_int"}, 64'(tim_int), 64'(e.tint));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic random_steps(input int n);
        stim_t s;
        logic  ten;
        ten = timer_en;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) ten = ~ten;
            s      = quiet(ten, ($urandom_range(0, 1) == 1));
            s.cen  = ($urandom_range(0, 1) == 1);
            s.clw  = ($urandom_range(0, 15) == 0);
            s.chw  = ($urandom_range(0, 15) == 0);
            s.mlw  = ($urandom_range(0, 15) == 0);
            s.mhw  = ($urandom_range(0, 15) == 0);
            s.ws   = 4'($urandom_range(0, 15));
            s.iclr = ($urandom_range(0, 7) == 0);
            s.oclr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       s.wd = m_cmp[31:0];
                1:       s.wd = 32'hFFFF_FFFF;
                default: s.wd = $urandom;
            endcase
            step(s, "random");
        end
    endtask

    initial begin
        stim_t s;
        model_reset();
        int_en = 1'b1;
        #12;
        chk("reset.cnt", cnt, 64'd0);
        chk("reset.cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("reset.int_st", 64'(int_st), 64'd0);
        chk("reset.ovf_st", 64'(ovf_st), 64'd0);
        chk("reset.tim_int", 64'(tim_int), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        tick(1, 1'b0);
        chk("first_tick.cnt", cnt, 64'd1);
        tick(4, 1'b0);
        chk("five_ticks.cnt", cnt, 64'd5);
        chk("five_ticks.cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("five_ticks.int_st", 64'(int_st), 64'd0);

        wr64(1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        tick(1, 1'b0);
        chk("half_carry.cnt", cnt, 64'h0000_0001_0000_0000);
        chk("half_carry.ovf_st", 64'(ovf_st), 64'd0);
        wr64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        tick(1, 1'b0);
        chk("wrap.cnt", cnt, 64'd0);
        chk("wrap.ovf_st", 64'(ovf_st), 64'd1);
        s = quiet(1'b1, 1'b0); s.oclr = 1'b1;
        step(s, "ovf_clr");
        chk("ovf_clr.ovf_st", 64'(ovf_st), 64'd0);

        wr64(1'b1, 64'd10, 1'b1, 1'b1);
        s = quiet(1'b1, 1'b1); s.iclr = 1'b1;
        step(s, "int_clr_pre");
        tick(10, 1'b1);
        chk("at_match.cnt", cnt, 64'd10);
        chk("at_match.int_st", 64'(int_st), 64'd0);
        step(quiet(1'b1, 1'b1), "hold_match");
        chk("match_next.int_st", 64'(int_st), 64'd1);
        chk("match_next.tim_int", 64'(tim_int), 64'd1);
        s = quiet(1'b1, 1'b1); s.iclr = 1'b1;
        step(s, "clr_during_match");
        chk("clr_during_match.int_st", 64'(int_st), 64'd1);
        tick(1, 1'b1);
        s = quiet(1'b1, 1'b1); s.iclr = 1'b1;
        step(s, "clr_after_match");
        chk("clr_after_match.int_st", 64'(int_st), 64'd0);

        wr64(1'b0, 64'h5566_7788_1122_3344, 1'b1, 1'b1);
        s = quiet(1'b1, 1'b1); s.cen = 1'b1; s.clw = 1'b1; s.wd = 32'hAABB_CCDD; s.ws = 4'b0101;
        step(s, "byte_merge_vs_tick");
        chk("byte_merge.cnt", cnt, 64'h5566_7788_11BB_33DD);

        wr64(1'b0, 64'd123, 1'b1, 1'b1);
        step(quiet(1'b0, 1'b1), "disable");
        chk("disable.cnt", cnt, 64'd0);
        for (int i = 0; i < 3; i++) begin
            s = quiet(1'b0, 1'b1); s.cen = 1'b1;
            step(s, "tick_while_disabled");
        end
        chk("disabled_ticks.cnt", cnt, 64'd0);

        wr64(1'b1, 64'd0, 1'b0, 1'b0);
        step(quiet(1'b0, 1'b0), "masked_match");
        chk("masked.int_st", 64'(int_st), 64'd1);
        chk("masked.tim_int", 64'(tim_int), 64'd0);
        int_en = 1'b1;
        #1;
        chk("unmask.tim_int", 64'(tim_int), 64'd1);

        random_steps(400);

        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_reset.cnt", cnt, 64'd0);
        chk("mid_reset.cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mid_reset.int_st", 64'(int_st), 64'd0);
        chk("mid_reset.ovf_st", 64'(ovf_st), 64'd0);
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(1, 1'b1);
        chk("post_reset_tick.cnt", cnt, 64'd1);
        random_steps(200);

        repeat (2) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
